// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared AES control types, datapath mux encodings and round constants
package aes_ctrl_pkg;

  localparam int NUM_ROUNDS  = 10;
  localparam int MAIN_ROUNDS = 9;

  localparam logic [1:0] SEL_ARK = 2'b00;
  localparam logic [1:0] SEL_SR  = 2'b01;
  localparam logic [1:0] SEL_SB  = 2'b10;
  localparam logic [1:0] SEL_MC  = 2'b11;

  typedef enum logic [4:0] {
    ST_REST      = 5'd0,
    ST_KEY_WAIT  = 5'd1,
    ST_ARK_INIT  = 5'd2,
    ST_SB_LOOP   = 5'd3,
    ST_SR_LOOP   = 5'd4,
    ST_MC_0      = 5'd5,
    ST_MC_1      = 5'd6,
    ST_MC_2      = 5'd7,
    ST_MC_3      = 5'd8,
    ST_ARK_LOOP  = 5'd9,
    ST_SB_END    = 5'd10,
    ST_SR_END    = 5'd11,
    ST_ARK_END   = 5'd12,
    ST_DONE      = 5'd13
  } enc_state_t;

endpackage

// File: rtl/aes_encrypt_driver.sv
// rtl/aes_encrypt_driver.sv - AES-128 encryption control FSM driving the shared state datapath
module aes_encrypt_driver
  import aes_ctrl_pkg::*;
#(
  parameter int KEY_WAIT = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start_h,
  input  logic [1407:0] KeySchedule,
  output logic          update_state,
  output logic          initialize,
  output logic [1:0]    WORD_SEL,
  output logic [1:0]    OUTPUT_SEL,
  output logic [127:0]  out_key,
  output logic          Done_h
);

  localparam logic [3:0] KW_LAST  = 4'(KEY_WAIT - 1);
  localparam logic [3:0] LAST_RND = 4'(MAIN_ROUNDS);

  enc_state_t state, next_state;
  logic [3:0] round_cnt, round_cnt_next;
  logic [3:0] wait_cnt, wait_cnt_next;

  // Round key r sits at bits [128r+127:128r]; out-of-range counts give zero.
  function automatic logic [127:0] round_key(input logic [1407:0] ks, input logic [3:0] r);
    logic [127:0] rk;
    rk = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (r == 4'(i)) rk = ks[128*i +: 128];
    end
    return rk;
  endfunction

  // State and counter registers with synchronous abort to Rest.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_REST;
      round_cnt <= 4'd0;
      wait_cnt  <= 4'd0;
    end else begin
      state     <= next_state;
      round_cnt <= round_cnt_next;
      wait_cnt  <= wait_cnt_next;
    end
  end

  // Next-state logic and Moore output decode of state/round_cnt.
  always_comb begin
    next_state     = state;
    round_cnt_next = round_cnt;
    wait_cnt_next  = wait_cnt;
    update_state   = 1'b1;
    initialize     = 1'b0;
    WORD_SEL       = 2'b00;
    OUTPUT_SEL     = SEL_ARK;
    out_key        = '0;
    Done_h         = 1'b0;
    case (state)
      ST_REST: begin
        update_state = 1'b0;
        if (Start_h) begin
          next_state    = ST_KEY_WAIT;
          wait_cnt_next = 4'd0;
        end
      end
      ST_KEY_WAIT: begin
        // Plaintext is captured once, while the key expansion settles.
        initialize = (wait_cnt == 4'd0);
        if (wait_cnt == KW_LAST) begin
          next_state    = ST_ARK_INIT;
          wait_cnt_next = 4'd0;
        end else begin
          wait_cnt_next = wait_cnt + 4'd1;
        end
      end
      ST_ARK_INIT: begin
        out_key        = round_key(KeySchedule, 4'd0);
        round_cnt_next = 4'd1;
        next_state     = ST_SB_LOOP;
      end
      ST_SB_LOOP: begin
        OUTPUT_SEL = SEL_SB;
        next_state = ST_SR_LOOP;
      end
      ST_SR_LOOP: begin
        OUTPUT_SEL = SEL_SR;
        next_state = ST_MC_0;
      end
      ST_MC_0: begin
        OUTPUT_SEL = SEL_MC;
        WORD_SEL   = 2'd0;
        next_state = ST_MC_1;
      end
      ST_MC_1: begin
        OUTPUT_SEL = SEL_MC;
        WORD_SEL   = 2'd1;
        next_state = ST_MC_2;
      end
      ST_MC_2: begin
        OUTPUT_SEL = SEL_MC;
        WORD_SEL   = 2'd2;
        next_state = ST_MC_3;
      end
      ST_MC_3: begin
        OUTPUT_SEL = SEL_MC;
        WORD_SEL   = 2'd3;
        next_state = ST_ARK_LOOP;
      end
      ST_ARK_LOOP: begin
        out_key = round_key(KeySchedule, round_cnt);
        if (round_cnt == LAST_RND) begin
          round_cnt_next = 4'd0;
          next_state     = ST_SB_END;
        end else begin
          round_cnt_next = round_cnt + 4'd1;
          next_state     = ST_SB_LOOP;
        end
      end
      ST_SB_END: begin
        OUTPUT_SEL = SEL_SB;
        next_state = ST_SR_END;
      end
      ST_SR_END: begin
        OUTPUT_SEL = SEL_SR;
        next_state = ST_ARK_END;
      end
      ST_ARK_END: begin
        out_key    = round_key(KeySchedule, 4'(NUM_ROUNDS));
        next_state = ST_DONE;
      end
      ST_DONE: begin
        update_state = 1'b0;
        Done_h       = 1'b1;
        // Start_h must drop before another run can begin.
        if (!Start_h) next_state = ST_REST;
      end
      default: begin
        update_state = 1'b0;
        next_state   = ST_REST;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_encrypt_driver.sv
// tb/tb_aes_encrypt_driver.sv - self-checking bench for aes_encrypt_driver
module tb_aes_encrypt_driver;
  import aes_ctrl_pkg::*;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start_h;
  logic [1407:0] KeySchedule;
  logic          update_state, initialize, Done_h;
  logic [1:0]    WORD_SEL, OUTPUT_SEL;
  logic [127:0]  out_key;

  aes_encrypt_driver #(.KEY_WAIT(10)) dut (
    .Clk(Clk), .Reset(Reset), .Start_h(Start_h), .KeySchedule(KeySchedule),
    .update_state(update_state), .initialize(initialize), .WORD_SEL(WORD_SEL),
    .OUTPUT_SEL(OUTPUT_SEL), .out_key(out_key), .Done_h(Done_h)
  );

  always #5 Clk = ~Clk;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam int TLEN = 78;

  typedef struct {
    bit         start;
    logic [6:0] ctl;   // {update_state, initialize, OUTPUT_SEL, WORD_SEL, Done_h}
    int         key;   // round key index, -1 means zero
  } vec_t;

  vec_t         tbl[TLEN];
  int           ti;
  logic [7:0]   sbox_t[256];
  logic [127:0] ks[11];
  logic [127:0] st;
  int           n_cmp = 0;
  int           n_err = 0;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox_t[s[8*k +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_col(input logic [127:0] s, input int w);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = s;
    {a0, a1, a2, a3} = s[127-32*w -: 32];
    o[127-32*w -: 32] = {gmul(a0,2)^gmul(a1,3)^a2^a3, a0^gmul(a1,2)^gmul(a2,3)^a3,
                         a0^a1^gmul(a2,2)^gmul(a3,3), gmul(a0,3)^a1^a2^gmul(a3,2)};
    return o;
  endfunction

  function automatic logic [6:0] mk(input logic u, input logic i, input logic [1:0] o,
                                    input logic [1:0] w, input logic d);
    return {u, i, o, w, d};
  endfunction

  // Behavioural 128-bit state datapath steered by the DUT's controls.
  always @(posedge Clk) begin
    if (update_state === 1'b1) begin
      if (initialize) st <= PT;
      else case (OUTPUT_SEL)
        SEL_ARK: st <= st ^ out_key;
        SEL_SR:  st <= shift_rows(st);
        SEL_SB:  st <= sub_bytes(st);
        default: st <= mix_col(st, int'(WORD_SEL));
      endcase
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic put(input logic [6:0] c, input int k);
    tbl[ti].start = 1'b1;
    tbl[ti].ctl   = c;
    tbl[ti].key   = k;
    ti++;
  endtask

  task automatic build();
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc, inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv,1) ^ rotl8(inv,2) ^ rotl8(inv,3) ^ rotl8(inv,4) ^ 8'h63;
    end
    {w[0], w[1], w[2], w[3]} = KEY;
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      KeySchedule[128*r +: 128] = ks[r];
    end
    ti = 0;
    for (int k = 0; k < 10; k++) put(mk(1, k == 0, SEL_ARK, 2'd0, 0), -1);
    put(mk(1, 0, SEL_ARK, 2'd0, 0), 0);
    for (int r = 1; r <= 9; r++) begin
      put(mk(1, 0, SEL_SB, 2'd0, 0), -1);
      put(mk(1, 0, SEL_SR, 2'd0, 0), -1);
      for (int k = 0; k < 4; k++) put(mk(1, 0, SEL_MC, 2'(k), 0), -1);
      put(mk(1, 0, SEL_ARK, 2'd0, 0), r);
    end
    put(mk(1, 0, SEL_SB, 2'd0, 0), -1);
    put(mk(1, 0, SEL_SR, 2'd0, 0), -1);
    put(mk(1, 0, SEL_ARK, 2'd0, 0), 10);
    put(mk(0, 0, SEL_ARK, 2'd0, 1), -1);
  endtask

  task automatic run_trace(input bit toggle, input string tag);
    logic [127:0] ek;
    Start_h = 1'b1;
    for (int i = 0; i < TLEN; i++) begin
      @(posedge Clk); #1;
      ek = (tbl[i].key < 0) ? 128'h0 : ks[tbl[i].key];
      check($sformatf("%s ctl[%0d]", tag, i),
            128'({update_state, initialize, OUTPUT_SEL, WORD_SEL, Done_h}), 128'(tbl[i].ctl));
      check($sformatf("%s key[%0d]", tag, i), out_key, ek);
      Start_h = (toggle && i >= 18 && i <= 45) ? i[0] : tbl[i].start;
    end
    check({tag, " ciphertext"}, st, CT);
  endtask

  task automatic drop_to_rest(input string tag);
    Start_h = 1'b0;
    @(posedge Clk); #1;
    check({tag, " state"}, 128'(dut.state), 128'(ST_REST));
    check({tag, " ctl"}, 128'({update_state, initialize, OUTPUT_SEL, WORD_SEL, Done_h}), 128'h0);
  endtask

  initial begin
    Reset = 1'b1;
    Start_h = 1'b0;
    build();
    repeat (2) @(posedge Clk);
    #1;
    check("reset state", 128'(dut.state), 128'(ST_REST));
    check("reset ctl", 128'({update_state, initialize, OUTPUT_SEL, WORD_SEL, Done_h}), 128'h0);
    check("reset key", out_key, 128'h0);
    Reset = 1'b0;
    @(posedge Clk); #1;
    check("idle state", 128'(dut.state), 128'(ST_REST));

    run_trace(1'b0, "run1");
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk); #1;
      check($sformatf("hold done_h[%0d]", i), 128'(Done_h), 128'h1);
      check($sformatf("hold state[%0d]", i), 128'(dut.state), 128'(ST_DONE));
    end
    drop_to_rest("drop1");

    run_trace(1'b0, "run2");
    drop_to_rest("drop2");

    run_trace(1'b1, "toggle");
    drop_to_rest("drop3");

    Start_h = 1'b1;
    for (int i = 0; i <= 36; i++) begin
      @(posedge Clk); #1;
    end
    check("mid state", 128'(dut.state), 128'(ST_MC_2));
    check("mid round", 128'(dut.round_cnt), 128'd4);
    Reset = 1'b1;
    Start_h = 1'b0;
    @(posedge Clk); #1;
    check("abort state", 128'(dut.state), 128'(ST_REST));
    check("abort round", 128'(dut.round_cnt), 128'd0);
    check("abort wait", 128'(dut.wait_cnt), 128'd0);
    check("abort ctl", 128'({update_state, initialize, OUTPUT_SEL, WORD_SEL, Done_h}), 128'h0);
    check("abort key", out_key, 128'h0);
    Reset = 1'b0;
    @(posedge Clk); #1;
    check("post abort state", 128'(dut.state), 128'(ST_REST));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
